// File: rtl/dmi_arbiter.sv
// dmi_arbiter: two-requester round-robin arbiter in front of a single DMI port.
// Only one transaction is outstanding at a time. Each response goes back to
// the requester that issued the request. Priority rotates to the other
// requester after every completed transaction.
//
// Optional feature macro: DMI_ARB_TIMEOUT_EN
//   When defined, a WAIT watchdog returns a synthetic "failed" response
//   (resp=2, data=0) after TIMEOUT_CYCLES cycles with no response. The late
//   response that eventually arrives is then absorbed by a drain flag.
//   When undefined, WAIT waits indefinitely and TIMEOUT_CYCLES is inert.

module dmi_arbiter #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [1:0]        m0_req_op,
  input  logic [DATA_W-1:0] m0_req_data,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  output logic [1:0]        m0_resp_resp,
  output logic [DATA_W-1:0] m0_resp_data,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [1:0]        m1_req_op,
  input  logic [DATA_W-1:0] m1_req_data,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [1:0]        m1_resp_resp,
  output logic [DATA_W-1:0] m1_resp_data,

  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic [1:0]        s_req_op,
  output logic [DATA_W-1:0] s_req_data,
  input  logic              s_resp_valid,
  output logic              s_resp_ready,
  input  logic [1:0]        s_resp_resp,
  input  logic [DATA_W-1:0] s_resp_data,

  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  localparam logic [1:0] RESP_FAILED = 2'd2;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_ptr;       // requester that wins a tie
  logic                r_owner;     // requester of current/last transaction
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_resp;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_sel;       // requester chosen in IDLE
  logic                w_load_req;  // request accepted this cycle
  logic                w_load_resp; // real response captured this cycle
  logic                w_timeout;   // watchdog fires this cycle
  logic                w_ret_done;  // owner accepted the response
  logic                w_drain_rdy; // extra s_resp_ready while draining

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_drain;
  logic                w_cnt_last;
  logic                w_discard;

  assign w_cnt_last  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // While draining, any response that shows up belongs to an abandoned
  // transaction and is thrown away.
  assign w_discard   = r_drain & s_resp_valid;
  assign w_drain_rdy = r_drain;
`else
  logic                w_unused_timeout;

  // The watchdog length only matters when the timeout feature is built in.
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_drain_rdy      = 1'b0;
`endif

  // Requests are forwarded from registers; responses are returned from registers.
  assign s_req_addr   = r_addr;
  assign s_req_op     = r_op;
  assign s_req_data   = r_wdata;
  assign m0_resp_resp = r_resp;
  assign m0_resp_data = r_rdata;
  assign m1_resp_resp = r_resp;
  assign m1_resp_data = r_rdata;
  assign owner        = r_owner;
  assign busy         = (r_state != ST_IDLE);

  // Next-state, grant and handshake decode for the transaction FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel         = 1'b0;
    w_load_req    = 1'b0;
    w_load_resp   = 1'b0;
    w_timeout     = 1'b0;
    w_ret_done    = 1'b0;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    s_req_valid   = 1'b0;
    s_resp_ready  = w_drain_rdy;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;

    // A tie goes to the pointer. Otherwise the lone requester wins.
    if (m0_req_valid && m1_req_valid) begin
      w_sel = r_ptr;
    end else begin
      w_sel = m1_req_valid;
    end

    case (r_state)
      ST_IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          m0_req_ready = ~w_sel;
          m1_req_ready = w_sel;
          w_load_req   = 1'b1;
          w_state_nxt  = ST_ISSUE;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        s_req_valid = 1'b1;
        if (s_req_ready) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_WAIT: begin
        s_resp_ready = 1'b1;
`ifdef DMI_ARB_TIMEOUT_EN
        // A real response beats the watchdog in the same cycle. A response
        // that arrives while draining belongs to the abandoned transaction.
        if (s_resp_valid && !r_drain) begin
          w_load_resp = 1'b1;
          w_state_nxt = ST_RETURN;
        end else if (w_cnt_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RETURN;
        end else begin
          w_state_nxt = ST_WAIT;
        end
`else
        if (s_resp_valid) begin
          w_load_resp = 1'b1;
          w_state_nxt = ST_RETURN;
        end else begin
          w_state_nxt = ST_WAIT;
        end
`endif
      end

      ST_RETURN: begin
        m0_resp_valid = ~r_owner;
        m1_resp_valid = r_owner;
        if (r_owner) begin
          w_ret_done = m1_resp_ready;
        end else begin
          w_ret_done = m0_resp_ready;
        end
        if (w_ret_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RETURN;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the granted requester's fields. They stay stable until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_op    <= 2'd0;
      r_wdata <= '0;
    end else if (w_load_req) begin
      r_owner <= w_sel;
      r_addr  <= w_sel ? m1_req_addr : m0_req_addr;
      r_op    <= w_sel ? m1_req_op   : m0_req_op;
      r_wdata <= w_sel ? m1_req_data : m0_req_data;
    end
  end

  // Capture the slave response, or a synthetic failure when the watchdog fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp  <= 2'd0;
      r_rdata <= '0;
    end else if (w_load_resp) begin
      r_resp  <= s_resp_resp;
      r_rdata <= s_resp_data;
    end else if (w_timeout) begin
      r_resp  <= RESP_FAILED;
      r_rdata <= '0;
    end
  end

  // Rotate priority away from the requester that just completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (w_ret_done) begin
      r_ptr <= ~r_owner;
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  // WAIT cycle counter. It is held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Drain flag: set by a timeout, cleared by the next response that arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drain <= 1'b0;
    end else if (w_timeout) begin
      r_drain <= 1'b1;
    end else if (w_discard) begin
      r_drain <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dmi_arbiter.sv
// Testbench for dmi_arbiter. A table of transactions is followed by
// randomized transactions checked against a transaction-level priority
// model, then hand sequences for contention, mid-transaction reset, and
// (with DMI_ARB_TIMEOUT_EN) the timeout/drain path.

module tb_dmi_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic [6:0]  m0_req_addr;
  logic [1:0]  m0_req_op, m0_resp_resp;
  logic [31:0] m0_req_data, m0_resp_data;
  logic        m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
  logic [6:0]  m1_req_addr;
  logic [1:0]  m1_req_op, m1_resp_resp;
  logic [31:0] m1_req_data, m1_resp_data;
  logic        s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [6:0]  s_req_addr;
  logic [1:0]  s_req_op, s_resp_resp;
  logic [31:0] s_req_data, s_resp_data;
  logic        owner, busy;

  int n_checks = 0;
  int n_errors = 0;
  bit ptr;  // model of the priority pointer

  typedef struct {
    bit          v0, v1;
    logic [6:0]  a0, a1;
    logic [1:0]  o0, o1;
    logic [31:0] d0, d1;
    int          req_stall, lat, resp_stall;
    logic [1:0]  sresp;
    logic [31:0] sdata;
    bit          exp_owner;
  } vec_t;

  dmi_arbiter #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_op(m0_req_op), .m0_req_data(m0_req_data), .m0_resp_valid(m0_resp_valid),
    .m0_resp_ready(m0_resp_ready), .m0_resp_resp(m0_resp_resp), .m0_resp_data(m0_resp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_op(m1_req_op), .m1_req_data(m1_req_data), .m1_resp_valid(m1_resp_valid),
    .m1_resp_ready(m1_resp_ready), .m1_resp_resp(m1_resp_resp), .m1_resp_data(m1_resp_data),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_op(s_req_op), .s_req_data(s_req_data), .s_resp_valid(s_resp_valid),
    .s_resp_ready(s_resp_ready), .s_resp_resp(s_resp_resp), .s_resp_data(s_resp_data),
    .owner(owner), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Tie priority goes to the pointer, otherwise to the only requester.
  function automatic bit ref_pick(input bit v0, input bit v1, input bit p);
    if (v0 && v1) return p;
    return v1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_m0_req_ready"},  m0_req_ready,  1'b0);
    chk({tag, "_m1_req_ready"},  m1_req_ready,  1'b0);
    chk({tag, "_s_req_valid"},   s_req_valid,   1'b0);
    chk({tag, "_s_resp_ready"},  s_resp_ready,  1'b0);
    chk({tag, "_m0_resp_valid"}, m0_resp_valid, 1'b0);
    chk({tag, "_m1_resp_valid"}, m1_resp_valid, 1'b0);
    chk({tag, "_busy"},          busy,          1'b0);
    chk({tag, "_owner"},         owner,         1'b0);
    chk({tag, "_s_req_addr"},    s_req_addr,    7'h0);
    chk({tag, "_s_req_op"},      s_req_op,      2'h0);
    chk({tag, "_s_req_data"},    s_req_data,    32'h0);
    chk({tag, "_m0_resp_data"},  m0_resp_data,  32'h0);
    chk({tag, "_m1_resp_resp"},  m1_resp_resp,  2'h0);
  endtask

  // One full transaction. It starts and ends at a falling edge with the DUT in IDLE.
  task automatic run_txn(input vec_t v);
    logic [6:0]  ea;
    logic [1:0]  eo;
    logic [31:0] ed;
    ea = v.exp_owner ? v.a1 : v.a0;
    eo = v.exp_owner ? v.o1 : v.o0;
    ed = v.exp_owner ? v.d1 : v.d0;
    // IDLE: grant is combinational
    m0_req_valid = v.v0; m0_req_addr = v.a0; m0_req_op = v.o0; m0_req_data = v.d0;
    m1_req_valid = v.v1; m1_req_addr = v.a1; m1_req_op = v.o1; m1_req_data = v.d1;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("grant_m0", m0_req_ready, v.exp_owner == 1'b0);
    chk("grant_m1", m1_req_ready, v.exp_owner == 1'b1);
    @(posedge clk); #1;
    // ISSUE: both requesters push, neither may be accepted
    for (int i = 0; i <= v.req_stall; i++) begin
      @(negedge clk);
      m0_req_valid = 1'b1; m1_req_valid = 1'b1;
      m0_req_addr = ~v.a0; m1_req_addr = ~v.a1;
      #1;
      chk("issue_valid", s_req_valid, 1'b1);
      chk("issue_addr", s_req_addr, ea);
      chk("issue_op", s_req_op, eo);
      chk("issue_data", s_req_data, ed);
      chk("issue_owner", owner, v.exp_owner);
      chk("issue_busy", busy, 1'b1);
      chk("issue_no_ready", {m1_req_ready, m0_req_ready}, 2'b00);
      s_req_ready = (i == v.req_stall);
    end
    @(posedge clk); #1;
    s_req_ready = 1'b0; m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    // WAIT: no duplicate request, no premature response
    for (int i = 0; i <= v.lat; i++) begin
      @(negedge clk);
      chk("wait_no_req", s_req_valid, 1'b0);
      chk("wait_resp_ready", s_resp_ready, 1'b1);
      chk("wait_no_mresp", {m1_resp_valid, m0_resp_valid}, 2'b00);
      if (i == v.lat) begin
        s_resp_valid = 1'b1; s_resp_resp = v.sresp; s_resp_data = v.sdata;
      end
    end
    @(posedge clk); #1;
    s_resp_valid = 1'b0; s_resp_data = 32'h5A5A5A5A; s_resp_resp = 2'd1;
    // RETURN: response held until the owner accepts. The other requester is always ready.
    for (int i = 0; i <= v.resp_stall; i++) begin
      @(negedge clk);
      chk("ret_valid", {m1_resp_valid, m0_resp_valid}, v.exp_owner ? 2'b10 : 2'b01);
      chk("ret_resp", v.exp_owner ? m1_resp_resp : m0_resp_resp, v.sresp);
      chk("ret_data", v.exp_owner ? m1_resp_data : m0_resp_data, v.sdata);
      chk("ret_no_sready", s_resp_ready, 1'b0);
      if (v.exp_owner) begin
        m1_resp_ready = (i == v.resp_stall); m0_resp_ready = 1'b1;
      end else begin
        m0_resp_ready = (i == v.resp_stall); m1_resp_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    @(negedge clk);
    chk("done_idle", busy, 1'b0);
    chk("done_no_mresp", {m1_resp_valid, m0_resp_valid}, 2'b00);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   gcyc[$];
  bit   gown[$];
  int   waited;
  bit   got;

  initial begin
    // Expected owners follow from pointer=0 after reset, rotating to ~owner each time.
    tbl[0] = '{1'b1, 1'b0, 7'h11, 7'h22, 2'd1, 2'd2, 32'h0,        32'h0,        0, 3, 0, 2'd0, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 7'h01, 7'h02, 2'd1, 2'd2, 32'h11111111, 32'h22222222, 0, 0, 0, 2'd0, 32'h0000A5A5, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 7'h03, 7'h04, 2'd2, 2'd1, 32'h33333333, 32'h44444444, 0, 0, 0, 2'd0, 32'h12345678, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 7'h05, 7'h7F, 2'd1, 2'd2, 32'h0,        32'hCAFEF00D, 5, 1, 3, 2'd0, 32'h87654321, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 7'h06, 7'h40, 2'd1, 2'd0, 32'h0,        32'h0,        0, 2, 1, 2'd3, 32'hFFFFFFFF, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 7'h7F, 7'h00, 2'd2, 2'd1, 32'hFFFFFFFF, 32'h1,        1, 0, 0, 2'd0, 32'h0,        1'b0};
    tbl[6] = '{1'b1, 1'b0, 7'h2A, 7'h00, 2'd1, 2'd1, 32'h0,        32'h0,        0, 4, 2, 2'd2, 32'h0BADC0DE, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 7'h10, 7'h20, 2'd1, 2'd2, 32'hAAAA5555, 32'h5555AAAA, 2, 2, 2, 2'd0, 32'h600DF00D, 1'b1};

    reset_n = 1'b0;
    m0_req_valid = 1'b0; m0_req_addr = 7'h0; m0_req_op = 2'd0; m0_req_data = 32'h0; m0_resp_ready = 1'b0;
    m1_req_valid = 1'b0; m1_req_addr = 7'h0; m1_req_op = 2'd0; m1_req_data = 32'h0; m1_resp_ready = 1'b0;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_resp = 2'd0; s_resp_data = 32'h0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    reset_n = 1'b1;
    ptr = 1'b0;

    // Table-driven transactions
    for (int k = 0; k < 8; k++) begin
      run_txn(tbl[k]);
      ptr = ~tbl[k].exp_owner;
    end

    // Randomized transactions against the priority model
    for (int t = 0; t < 40; t++) begin
      rv.v0 = 1'($urandom_range(0, 1));
      rv.v1 = 1'($urandom_range(0, 1));
      if (!rv.v0 && !rv.v1) rv.v1 = 1'b1;
      rv.a0 = 7'($urandom); rv.a1 = 7'($urandom);
      rv.o0 = 2'($urandom_range(0, 2)); rv.o1 = 2'($urandom_range(0, 2));
      rv.d0 = $urandom; rv.d1 = $urandom;
      rv.req_stall  = $urandom_range(0, 3);
      rv.lat        = $urandom_range(0, 5);
      rv.resp_stall = $urandom_range(0, 3);
      rv.sresp = 2'($urandom_range(0, 3));
      rv.sdata = $urandom;
      rv.exp_owner = ref_pick(rv.v0, rv.v1, ptr);
      run_txn(rv);
      ptr = ~rv.exp_owner;
    end

    // Contention: both requesters valid continuously, zero-wait slave
    m0_req_valid = 1'b1; m0_req_addr = 7'h0A; m0_req_op = 2'd1;
    m1_req_valid = 1'b1; m1_req_addr = 7'h0B; m1_req_op = 2'd2;
    s_req_ready = 1'b1; s_resp_valid = 1'b1; s_resp_resp = 2'd0; s_resp_data = 32'hC0FFEE00;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("cont_excl_ready", m0_req_ready & m1_req_ready, 1'b0);
      if (m0_req_ready || m1_req_ready) begin
        gcyc.push_back(i);
        gown.push_back(m1_req_ready);
      end
      if ((m0_resp_valid || m1_resp_valid) && gown.size() > 0) begin
        chk("cont_resp_route", {m1_resp_valid, m0_resp_valid}, gown[$] ? 2'b10 : 2'b01);
        chk("cont_owner", owner, gown[$]);
      end
      if (i == 23) begin
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    @(negedge clk);
    chk("cont_idle", busy, 1'b0);
    chk("cont_grants", gcyc.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < gcyc.size()) begin
        chk("cont_alternate", gown[k], ptr);
        chk("cont_period", gcyc[k], 4 * k);
      end
      ptr = ~ptr;
    end

    // Reset mid-transaction: first make the pointer 1, then abandon an m1 transaction in WAIT.
    rv = '{1'b1, 1'b0, 7'h33, 7'h0, 2'd1, 2'd0, 32'h0, 32'h0, 0, 0, 0, 2'd0, 32'h13579BDF, 1'b0};
    run_txn(rv);
    ptr = 1'b1;
    m1_req_valid = 1'b1; m1_req_addr = 7'h55; m1_req_op = 2'd2; m1_req_data = 32'hFEEDFACE;
    #1;
    chk("rst_pre_grant_m1", m1_req_ready, ref_pick(1'b0, 1'b1, ptr));
    @(posedge clk); #1;
    m1_req_valid = 1'b0;
    @(negedge clk);
    s_req_ready = 1'b1;
    @(posedge clk); #1;
    s_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_in_wait", s_resp_ready, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    ptr = 1'b0;
    // A late response from the abandoned transaction must not reach anyone.
    s_resp_valid = 1'b1; s_resp_data = 32'h99999999;
    @(posedge clk); #1;
    s_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_mresp", {m1_resp_valid, m0_resp_valid}, 2'b00);
      chk("midrst_idle", busy, 1'b0);
    end
    rv = '{1'b1, 1'b1, 7'h44, 7'h45, 2'd1, 2'd1, 32'h0, 32'h0, 0, 1, 0, 2'd0, 32'h2468ACE0, 1'b0};
    rv.exp_owner = ref_pick(1'b1, 1'b1, ptr);
    run_txn(rv);
    ptr = ~rv.exp_owner;

`ifdef DMI_ARB_TIMEOUT_EN
    // Timeout: silent slave, synthetic failure after 8 WAIT cycles.
    m0_req_valid = 1'b1; m0_req_addr = 7'h12; m0_req_op = 2'd1; m0_req_data = 32'h0;
    #1;
    chk("to_grant_m0", m0_req_ready, 1'b1);
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    @(negedge clk);
    s_req_ready = 1'b1;
    @(posedge clk); #1;
    s_req_ready = 1'b0;
    waited = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (m0_resp_valid) got = 1'b1;
      else waited++;
    end
    chk("to_resp_seen", got, 1'b1);
    chk("to_wait_cycles", waited, 8);
    chk("to_resp_code", m0_resp_resp, 2'd2);
    chk("to_resp_data", m0_resp_data, 32'h0);
    chk("to_m1_quiet", m1_resp_valid, 1'b0);
    m0_resp_ready = 1'b1;
    @(posedge clk); #1;
    m0_resp_ready = 1'b0;
    ptr = 1'b1;
    @(negedge clk);
    chk("to_idle", busy, 1'b0);
    chk("to_drain_ready", s_resp_ready, 1'b1);
    s_resp_valid = 1'b1; s_resp_data = 32'h77777777;
    @(posedge clk); #1;
    s_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_stray_absorbed", {m1_resp_valid, m0_resp_valid}, 2'b00);
      chk("to_drain_clear", s_resp_ready, 1'b0);
    end
    rv = '{1'b1, 1'b1, 7'h61, 7'h62, 2'd1, 2'd2, 32'h0, 32'hABCDEF01, 0, 2, 0, 2'd0, 32'h31415926, 1'b0};
    rv.exp_owner = ref_pick(1'b1, 1'b1, ptr);
    run_txn(rv);
    ptr = ~rv.exp_owner;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
